// File: rtl/test_status_monitor_pkg.sv
// Shared types and helpers for the test status monitor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package test_status_pkg;

    localparam int ST_W = 3;
    localparam int FF_W = 5;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_e;

    // Lowest set bit index of a channel vector (zero-extended to 32 bits); 0 if none set.
    function automatic logic [FF_W-1:0] lowest_set(input logic [31:0] vec);
        logic [FF_W-1:0] idx;
        idx = '0;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) idx = FF_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/test_status_monitor_if.sv
// Strobe inputs and status outputs of the test status monitor.
// Latency: n/a (wiring only).
// Backpressure: none; strobes are fire-and-forget, status is level.
interface test_status_monitor_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
) ();
    import test_status_pkg::*;

    logic                start;
    logic                kick;
    logic [NUM_CH-1:0]   pass;
    logic [NUM_CH-1:0]   fail;
    logic [ST_W-1:0]     state;
    logic                done;
    logic                test_passed;
    logic                test_failed;
    logic                timed_out;
    logic [NUM_CH-1:0]   pass_mask;
    logic [NUM_CH-1:0]   fail_mask;
    logic [FF_W-1:0]     first_fail_ch;
    logic [CNT_W-1:0]    cycle_count;

    modport master (
        output start, kick, pass, fail,
        input  state, done, test_passed, test_failed, timed_out,
               pass_mask, fail_mask, first_fail_ch, cycle_count
    );

    modport slave (
        input  start, kick, pass, fail,
        output state, done, test_passed, test_failed, timed_out,
               pass_mask, fail_mask, first_fail_ch, cycle_count
    );

endinterface

// File: rtl/test_status_monitor_watchdog.sv
// Watchdog counter: counts enabled cycles, flags expiry at TIMEOUT-1.
// Latency: expire is combinational from the registered count.
// Backpressure: none; clr has priority over enable.
module test_watchdog #(
    parameter int          CNT_W   = 32,
    parameter int unsigned TIMEOUT = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise advance while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr)     cnt_d = '0;
        else if (en) cnt_d = cnt_q + CNT_W'(1);
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign expire = en && (cnt_q == LIMIT);

endmodule

// File: rtl/test_status_monitor.sv
// Multi-channel pass/fail/timeout monitor resolving to one terminal verdict.
// Latency: strobe sampled at edge N is reflected in state/masks after edge N.
// Backpressure: none; strobes are sampled every RUN cycle, ignored elsewhere.
module test_status_monitor
    import test_status_pkg::*;
#(
    parameter int          NUM_CH   = 4,
    parameter int          CNT_W    = 32,
    parameter int unsigned TIMEOUT  = 100000,
    parameter bit          PASS_ALL = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    test_status_monitor_if.slave  bus
);

    logic [1:0]        rst_sync_q;
    logic [1:0]        rst_sync_d;
    logic              rst_n;

    state_e            state_q, state_d;
    logic [NUM_CH-1:0] pass_mask_q, pass_mask_d;
    logic [NUM_CH-1:0] fail_mask_q, fail_mask_d;
    logic [FF_W-1:0]   first_fail_ch_q, first_fail_ch_d;
    logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;

    logic [NUM_CH-1:0] fm_eff;
    logic [NUM_CH-1:0] pm_eff;
    logic [NUM_CH-1:0] fail_new;
    logic              pass_ok;
    logic              in_run;
    logic              wd_clr;
    logic              wd_expire;

    // Reset release is retimed to clk; assertion stays asynchronous.
    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
    end

    // Reset synchronizer stages.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= '0;
        else          rst_sync_q <= rst_sync_d;
    end

    assign rst_n  = rst_sync_q[1];
    assign in_run = (state_q == ST_RUN);
    assign wd_clr = bus.start || (in_run && bus.kick);

    test_watchdog #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (wd_clr),
        .en     (in_run),
        .expire (wd_expire)
    );

    // Effective masks for this cycle; a same-cycle fail overrides a pass.
    always_comb begin
        fm_eff   = fail_mask_q | bus.fail;
        pm_eff   = (pass_mask_q | bus.pass) & ~fm_eff;
        fail_new = fm_eff & ~fail_mask_q;
        pass_ok  = PASS_ALL ? (&pm_eff) : (|pm_eff);
    end

    // Next state, mask, first-fail and cycle-count logic.
    always_comb begin
        state_d         = state_q;
        pass_mask_d     = pass_mask_q;
        fail_mask_d     = fail_mask_q;
        first_fail_ch_d = first_fail_ch_q;
        cycle_count_d   = cycle_count_q;

        if (bus.start) begin
            state_d         = ST_RUN;
            pass_mask_d     = '0;
            fail_mask_d     = '0;
            first_fail_ch_d = '0;
            cycle_count_d   = '0;
        end else if (in_run) begin
            pass_mask_d = pm_eff;
            fail_mask_d = fm_eff;
            if (cycle_count_q != '1) cycle_count_d = cycle_count_q + CNT_W'(1);
            if ((fail_mask_q == '0) && (fm_eff != '0))
                first_fail_ch_d = lowest_set(32'(fail_new));

            if (fm_eff != '0)                state_d = ST_FAIL;
            else if (pass_ok)                state_d = ST_PASS;
            else if (wd_expire && !bus.kick) state_d = ST_TIMEOUT;
        end
    end

    // Monitor state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            pass_mask_q     <= '0;
            fail_mask_q     <= '0;
            first_fail_ch_q <= '0;
            cycle_count_q   <= '0;
        end else begin
            state_q         <= state_d;
            pass_mask_q     <= pass_mask_d;
            fail_mask_q     <= fail_mask_d;
            first_fail_ch_q <= first_fail_ch_d;
            cycle_count_q   <= cycle_count_d;
        end
    end

    assign bus.state         = state_q;
    assign bus.test_passed   = (state_q == ST_PASS);
    assign bus.test_failed   = (state_q == ST_FAIL);
    assign bus.timed_out     = (state_q == ST_TIMEOUT);
    assign bus.done          = bus.test_passed | bus.test_failed | bus.timed_out;
    assign bus.pass_mask     = pass_mask_q;
    assign bus.fail_mask     = fail_mask_q;
    assign bus.first_fail_ch = first_fail_ch_q;
    assign bus.cycle_count   = cycle_count_q;

endmodule
